// File: rtl/csr_regfile.sv
// Machine-mode CSR storage (mcause, mstatus, mepc, mtvec) with WARL write masking,
// plus free-running mcycle/minstret counters.
module csr_regfile #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] csrf_raddr,
    output logic [DATA_WIDTH-1:0] csrf_rdata,
    input  logic [ADDR_WIDTH-1:0] csrf_waddr,
    input  logic [DATA_WIDTH-1:0] csrf_wdata,
    input  logic                  csrf_wen,
    input  logic                  instr_retire,
    output logic [DATA_WIDTH-1:0] mtvec_o,
    output logic [DATA_WIDTH-1:0] mepc_o,
    output logic                  mie_o,
    output logic [63:0]           cycle_o,
    output logic [63:0]           instret_o
);

    typedef enum logic [1:0] {
        CSR_MCAUSE  = 2'd0,
        CSR_MSTATUS = 2'd1,
        CSR_MEPC    = 2'd2,
        CSR_MTVEC   = 2'd3
    } csr_idx_e;

    // UXL = SXL = 2 (64-bit), every other unimplemented field reads zero.
    localparam logic [63:0] MSTATUS_FIXED = 64'h0000_000A_0000_0000;

    logic [63:0] mcause_q,  mcause_d;
    logic [63:2] mepc_q,    mepc_d;
    logic [63:2] mtvec_q,   mtvec_d;
    logic        mie_q,     mie_d;
    logic        mpie_q,    mpie_d;
    logic [1:0]  mpp_q,     mpp_d;
    logic [63:0] cycle_q,   cycle_d;
    logic [63:0] instret_q, instret_d;

    logic [63:0] mstatus_rd;

    assign mstatus_rd = MSTATUS_FIXED
                      | {51'd0, mpp_q, 11'd0}
                      | {56'd0, mpie_q, 7'd0}
                      | {60'd0, mie_q, 3'd0};

    always_comb begin
        mcause_d  = mcause_q;
        mepc_d    = mepc_q;
        mtvec_d   = mtvec_q;
        mie_d     = mie_q;
        mpie_d    = mpie_q;
        mpp_d     = mpp_q;
        cycle_d   = cycle_q + 64'd1;
        instret_d = instret_q + {63'd0, instr_retire};
        if (csrf_wen) begin
            case (csr_idx_e'(csrf_waddr))
                CSR_MCAUSE:  mcause_d = csrf_wdata;
                CSR_MSTATUS: begin
                    mie_d  = csrf_wdata[3];
                    mpie_d = csrf_wdata[7];
                    mpp_d  = csrf_wdata[12:11];
                end
                CSR_MEPC:    mepc_d  = csrf_wdata[63:2];
                CSR_MTVEC:   mtvec_d = csrf_wdata[63:2];
                default:     ;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge values; reset is checked first so it discards a concurrent write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcause_q  <= '0;
            mepc_q    <= '0;
            mtvec_q   <= '0;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
            mpp_q     <= 2'b11;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            mcause_q  <= mcause_d;
            mepc_q    <= mepc_d;
            mtvec_q   <= mtvec_d;
            mie_q     <= mie_d;
            mpie_q    <= mpie_d;
            mpp_q     <= mpp_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    // Read path comes only from stored state: csrrs feeds rdata back into wdata.
    always_comb begin
        csrf_rdata = '0;
        case (csr_idx_e'(csrf_raddr))
            CSR_MCAUSE:  csrf_rdata = mcause_q;
            CSR_MSTATUS: csrf_rdata = mstatus_rd;
            CSR_MEPC:    csrf_rdata = {mepc_q, 2'b00};
            CSR_MTVEC:   csrf_rdata = {mtvec_q, 2'b00};
            default:     csrf_rdata = '0;
        endcase
    end

    assign mtvec_o   = {mtvec_q, 2'b00};
    assign mepc_o    = {mepc_q, 2'b00};
    assign mie_o     = mie_q;
    assign cycle_o   = cycle_q;
    assign instret_o = instret_q;

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode CSR register file in the EXU: the storage end of the `csrf_*` port driven by the system-instruction controller. Holds mcause, mstatus, mepc and mtvec behind a 2-bit index. Applies WARL write masking and exposes trap-vector/return-address values to fetch. Also maintains free-running mcycle and minstret counters.

## Interface
- ADDR_WIDTH, 2, CSR index width; only 2 supported
- DATA_WIDTH, 64, CSR data width; only 64 supported (mstatus constant fields assume RV64)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- csrf_raddr  input  ADDR_WIDTH  read index: 0 mcause, 1 mstatus, 2 mepc, 3 mtvec
- csrf_rdata  output  DATA_WIDTH  read data, combinational from stored state
- csrf_waddr  input  ADDR_WIDTH  write index, same map
- csrf_wdata  input  DATA_WIDTH  write data, pre-mask
- csrf_wen  input  1  write enable, sampled at rising edge
- instr_retire  input  1  one-cycle pulse per retired instruction
- mtvec_o  output  DATA_WIDTH  current masked mtvec
- mepc_o  output  DATA_WIDTH  current masked mepc
- mie_o  output  1  mstatus.MIE
- cycle_o  output  64  mcycle
- instret_o  output  64  minstret

## Operation
- Storage: mcause 64 b full; mepc bits [63:2] only; mtvec bits [63:2] only; mstatus holds MIE (bit 3), MPIE (bit 7), MPP (bits 12:11) only.
- Write masking on csrf_wen:
  - mcause stores wdata unmodified.
  - mepc stores wdata[63:2]; bits [1:0] always read 0.
  - mtvec stores wdata[63:2]; MODE bits [1:0] always read 0 (direct only).
  - mstatus stores wdata bits 3, 7, 12:11. UXL (bits 33:32) and SXL (bits 35:34) are hardwired 2'b10. All other bits are hardwired 0 and ignore writes.
- Read: csrf_rdata = masked stored value selected by csrf_raddr. The read path has no write bypass. This is mandatory: the controller computes csrrs data as src1 | csrf_rdata, so a bypass would create a combinational loop.
- mtvec_o, mepc_o and mie_o are driven directly from stored state, independent of csrf_raddr.
- mcycle: +1 every cycle while rst_n is high.
- minstret: +1 on each cycle where instr_retire is high.
- Both counters are 64-bit and wrap modulo 2^64 with no flag.
- Counters are not writable through csrf_*.

## Timing
- Reset values (outputs in the cycle after the rst_n-low edge):
  - mcause = 0
  - mstatus = 64'h0000_000A_0000_1800 (MPP = 3, UXL = SXL = 2, MIE = MPIE = 0)
  - mepc = 0, mtvec = 0
  - cycle_o = 0, instret_o = 0, mie_o = 0
  - csrf_rdata follows the reset state through the read mux.
- Write latency: 1 cycle. A write sampled at edge N is visible on csrf_rdata, mtvec_o and mepc_o after edge N.
- Same-cycle read and write of the same index: csrf_rdata returns the old value in that cycle and the new value the next cycle.
- Back-to-back writes on consecutive cycles (e.g. mepc, then mcause for ecall) are each accepted; there is no stall or busy state.
- rst_n low together with csrf_wen high: reset wins and the write is discarded.
- Reset mid-count: counters return to 0, then resume counting on the first edge with rst_n high.
- After reset, mcycle reads 0 in the first cycle, 1 after the next edge, and so on.
- Counter wrap: 64'hFFFF_FFFF_FFFF_FFFF + 1 -> 0 on the next edge. minstret wraps the same way when instr_retire is high.

## Test plan
- Reset, then read indices 0–3 with no writes -> 0, 64'hA_0000_1800, 0, 0; cycle_o increments by 1 per cycle starting from 0.
- Write mepc = 64'h8000_0007 and mtvec = 64'h8000_0103 on consecutive cycles -> reads return 64'h8000_0004 and 64'h8000_0100; mepc_o and mtvec_o match from the cycle after each write.
- Write mstatus = all ones -> read returns 64'hA_0000_1888, mie_o = 1; then write 0 -> read returns 64'hA_0000_0000, mie_o = 0.
- Hold csrf_wen = 1 with waddr = raddr = 0 and wdata = 64'h5 while mcause = 64'hb -> csrf_rdata = 64'hb in that cycle and 64'h5 in the next.
- Pulse instr_retire on 3 of 5 cycles -> instret_o = 3. Then force the counters near wrap by running from a preloaded 64'hFFFF_FFFF_FFFF_FFFE in a hierarchical-force test -> 64'hFFFF_FFFF_FFFF_FFFF, then 0.
- Assert rst_n low for one cycle during a write of mcause = 64'hb with counters nonzero -> mcause = 0 and counters = 0 afterward; mstatus returns to 64'hA_0000_1800.
